// File: rtl/rv32_instr_byte_loader.sv
// rtl/rv32_instr_byte_loader.sv - assembles RV32I words from a byte stream into a small instruction FIFO
module rv32_instr_byte_loader #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  input  logic                     flush,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [1:0]               byte_idx,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   asm_word;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    idx_q;
  logic [AW:0]   level_q;

  logic last_slot;
  logic pop;
  logic accept;
  logic push;

  // Only the word-completing byte can be backpressured; a same-cycle pop frees its slot.
  always_comb begin
    last_slot  = (idx_q == 2'd3);
    pop        = (level_q != '0) && instr_ready;
    byte_ready = !last_slot || (level_q < FULL) || pop;
    accept     = byte_valid && byte_ready;
    push       = accept && last_slot;
  end

  assign instr_valid = (level_q != '0);
  assign instr       = (level_q != '0) ? mem[rd_ptr] : NOP_INSTR;
  assign byte_idx    = idx_q;
  assign level       = level_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      asm_word <= '0;
      idx_q    <= '0;
      level_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (accept) begin
        idx_q <= idx_q + 2'd1;
        if (!last_slot) begin
          asm_word[{idx_q, 3'b000} +: 8] <= byte_in;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + (AW+1)'(1);
      end else if (!push && pop) begin
        level_q <= level_q - (AW+1)'(1);
      end
    end
  end

  // The completing byte goes straight into the FIFO alongside the three staged bytes.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= {byte_in, asm_word[23:0]};
    end
  end

endmodule

// File: tb/tb_rv32_instr_byte_loader.sv
// tb/tb_rv32_instr_byte_loader.sv - scoreboard bench for rv32_instr_byte_loader
module tb_rv32_instr_byte_loader;

  localparam int          DEPTH = 2;
  localparam int          LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          flush = 1'b0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [1:0]    byte_idx;
  logic [LW-1:0] level;

  rv32_instr_byte_loader #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .flush(flush),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .byte_idx(byte_idx),
    .level(level)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pops   = 0;

  // Reference model: bytes of the word being gathered, and the words the core has yet to take.
  logic [7:0]  partial[$];
  logic [31:0] sb_q[$];
  logic        exp_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] head;
    head = (sb_q.size() != 0) ? sb_q[0] : NOP;
    check("instr", instr, head);
    check("instr_valid", 32'(instr_valid), 32'(sb_q.size() != 0));
    check("level", 32'(level), 32'(sb_q.size()));
    check("byte_idx", 32'(byte_idx), 32'(partial.size()));
    exp_ready = (partial.size() != 3) || (sb_q.size() < DEPTH) || ((sb_q.size() != 0) && instr_ready);
    check("byte_ready", 32'(byte_ready), 32'(exp_ready));
    if (!rst && !flush && instr_ready && sb_q.size() != 0) begin
      void'(sb_q.pop_front());
      pops++;
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic f, input logic x, output logic acc);
    byte_valid  = v;
    byte_in     = d;
    instr_ready = r;
    flush       = f;
    rst         = x;
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (x || f) begin
      partial.delete();
      sb_q.delete();
    end else if (v && exp_ready) begin
      acc = 1'b1;
      partial.push_back(d);
      if (partial.size() == 4) begin
        sb_q.push_back({partial[3], partial[2], partial[1], partial[0]});
        partial.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic r);
    logic acc;
    int   tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 50) begin
      step(1'b1, d, r, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_byte_timeout: got stalled expected accept of %h", d);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic r);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], r);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00, r, 1'b0, 1'b0, acc);
    end
  endtask

  task automatic do_reset();
    logic acc;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First instruction: 13 05 10 00 -> 00100513
    send_word(32'h00100513, 1'b0);
    idle(2, 1'b0);

    // Fill DEPTH=2, stall the word-completing 12th byte, then release with a pop
    do_reset();
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b0);
    send_byte(8'hd4, 1'b0);
    send_byte(8'hc3, 1'b0);
    send_byte(8'hb2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'ha1, 1'b0, 1'b0, 1'b0, acc);
    end
    step(1'b1, 8'ha1, 1'b1, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    idle(4, 1'b1);

    // Steady stream with the core always ready
    send_word(32'h00a00093, 1'b1);
    send_word(32'h00108133, 1'b1);
    send_word(32'hfe209ee3, 1'b1);
    idle(3, 1'b1);

    // Flush with a concurrent third byte
    send_byte(8'hde, 1'b0);
    send_byte(8'had, 1'b0);
    step(1'b1, 8'hbe, 1'b0, 1'b1, 1'b0, acc);
    send_word(32'h00a00093, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Reset with a full FIFO and a half-built word
    send_word(32'hcafef00d, 1'b0);
    send_word(32'h0badc0de, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    idle(2, 1'b0);

    // Core ready against an empty FIFO
    idle(10, 1'b1);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 4000; i++) begin
      logic v, r, f, x;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 63) == 0);
      x = ($urandom_range(0, 199) == 0);
      step(v, 8'($urandom), r, f, x, acc);
    end

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      idle(1, 1'b1);
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d words left expected 0", sb_q.size());
    end
    idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
